// File: rtl/fsb_pcim_line_packer.sv
// Packs 80-bit FSB packets into 512-bit PCIM lines: accumulator plus output register.
// Optional macro FSB_PCIM_PACKER_SEQ_EN stamps a 24-bit line sequence into bits [511:488].
module fsb_pcim_line_packer #(
    parameter int fsb_width_p    = 80,
    parameter int line_width_p   = 512,
    parameter int flush_cycles_p = 64,
    parameter int timer_width_p  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    fsb_v_i,
    input  logic [fsb_width_p-1:0]  fsb_data_i,
    output logic                    fsb_yumi_o,
    input  logic                    flush_i,
    output logic                    line_v_o,
    output logic [line_width_p-1:0] line_data_o,
    output logic [2:0]              line_count_o,
    input  logic                    line_ready_i,
    output logic                    busy_o
`ifdef FSB_PCIM_PACKER_SEQ_EN
    ,
    output logic [23:0]             line_seq_o
`endif
);

    localparam int slots_p = line_width_p / fsb_width_p;
    localparam int slot_bits_lp = slots_p * fsb_width_p;

    logic [slots_p-1:0][fsb_width_p-1:0] acc_q, acc_d;
    logic [2:0]                          acc_cnt_q, acc_cnt_d;
    logic [timer_width_p-1:0]            timer_q, timer_d;
    logic                                pend_q, pend_d;
    logic                                line_v_q, line_v_d;
    logic [line_width_p-1:0]             line_q, line_d;
    logic [2:0]                          line_cnt_q, line_cnt_d;
`ifdef FSB_PCIM_PACKER_SEQ_EN
    logic [23:0]                         seq_q, seq_d;
`endif

    logic       full, nonempty, timeout, yumi, emit, out_free, xfer;
    logic [2:0] wr_idx;

    assign full     = (acc_cnt_q == 3'(slots_p));
    assign nonempty = (acc_cnt_q != 3'd0);
    assign timeout  = (flush_cycles_p != 0) && (timer_q >= timer_width_p'(flush_cycles_p));
    assign yumi     = fsb_v_i & ~full & ~reset_i;
    // pend_q remembers a flush/timeout that arrived while the output register was blocked
    assign emit     = full | (nonempty & (flush_i | timeout | pend_q));
    assign out_free = ~line_v_q | line_ready_i;
    assign xfer     = emit & out_free;
    assign wr_idx   = xfer ? 3'd0 : acc_cnt_q;

    always_comb begin
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        timer_d    = timer_q;
        pend_d     = pend_q;
        line_v_d   = line_v_q & ~line_ready_i;
        line_d     = line_q;
        line_cnt_d = line_cnt_q;
`ifdef FSB_PCIM_PACKER_SEQ_EN
        seq_d      = seq_q;
`endif

        if (xfer) begin
            acc_d      = '0;
            acc_cnt_d  = 3'd0;
            line_v_d   = 1'b1;
            line_d     = '0;
            line_d[slot_bits_lp-1:0]  = acc_q;
            line_d[slot_bits_lp +: 8] = 8'(acc_cnt_q);
            line_cnt_d = acc_cnt_q;
`ifdef FSB_PCIM_PACKER_SEQ_EN
            line_d[line_width_p-1 -: 24] = seq_q;
            seq_d      = seq_q + 24'd1;
`endif
        end

        if (yumi) begin
            for (int k = 0; k < slots_p; k++)
                if (wr_idx == 3'(k)) acc_d[k] = fsb_data_i;
            acc_cnt_d = wr_idx + 3'd1;
        end

        if (yumi || xfer || !nonempty)
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + timer_width_p'(1);

        if (xfer)
            pend_d = 1'b0;
        else if (nonempty && (flush_i || timeout))
            pend_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q      <= '0;
            acc_cnt_q  <= 3'd0;
            timer_q    <= '0;
            pend_q     <= 1'b0;
            line_v_q   <= 1'b0;
            line_q     <= '0;
            line_cnt_q <= 3'd0;
`ifdef FSB_PCIM_PACKER_SEQ_EN
            seq_q      <= 24'd0;
`endif
        end else begin
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            line_v_q   <= line_v_d;
            line_q     <= line_d;
            line_cnt_q <= line_cnt_d;
`ifdef FSB_PCIM_PACKER_SEQ_EN
            seq_q      <= seq_d;
`endif
        end
    end

    assign fsb_yumi_o   = yumi;
    assign line_v_o     = line_v_q;
    assign line_data_o  = line_q;
    assign line_count_o = line_cnt_q;
    assign busy_o       = line_v_q | nonempty;
`ifdef FSB_PCIM_PACKER_SEQ_EN
    assign line_seq_o   = line_q[line_width_p-1 -: 24];
`endif

endmodule

// File: tb/tb_fsb_pcim_line_packer.sv
// Directed + scoreboard bench for fsb_pcim_line_packer (default parameters).
module tb_fsb_pcim_line_packer;

    logic         clk = 1'b0;
    logic         reset_i, fsb_v_i, flush_i, line_ready_i;
    logic [79:0]  fsb_data_i;
    logic         fsb_yumi_o, line_v_o, busy_o;
    logic [511:0] line_data_o;
    logic [2:0]   line_count_o;
`ifdef FSB_PCIM_PACKER_SEQ_EN
    logic [23:0]  line_seq_o;
`endif

    always #5 clk = ~clk;

    fsb_pcim_line_packer dut (
        .clk_i(clk), .reset_i(reset_i),
        .fsb_v_i(fsb_v_i), .fsb_data_i(fsb_data_i), .fsb_yumi_o(fsb_yumi_o),
        .flush_i(flush_i),
        .line_v_o(line_v_o), .line_data_o(line_data_o), .line_count_o(line_count_o),
        .line_ready_i(line_ready_i), .busy_o(busy_o)
`ifdef FSB_PCIM_PACKER_SEQ_EN
        , .line_seq_o(line_seq_o)
`endif
    );

    int          ncmp = 0;
    int          nerr = 0;
    logic [23:0] exp_seq = '0;
    logic [79:0] q[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pk(input logic [7:0] tag, input int i);
        return {tag, 40'h0, 32'(i)};
    endfunction

    function automatic logic [5:0][79:0] slots(input logic [7:0] tag, input int base, input int cnt);
        logic [5:0][79:0] s;
        s = '0;
        for (int k = 0; k < cnt; k++) s[k] = pk(tag, base + k);
        return s;
    endfunction

    function automatic logic [511:0] mk(input logic [5:0][79:0] s, input int cnt);
        logic [511:0] l;
        l = '0;
        l[479:0]   = s;
        l[487:480] = 8'(cnt);
`ifdef FSB_PCIM_PACKER_SEQ_EN
        l[511:488] = exp_seq;
`endif
        return l;
    endfunction

    task automatic chk_line(input string tag, input logic [5:0][79:0] s, input int cnt);
        chk({tag, "_v"}, 512'(line_v_o), 512'(1));
        chk({tag, "_data"}, line_data_o, mk(s, cnt));
        chk({tag, "_cnt"}, 512'(line_count_o), 512'(cnt));
`ifdef FSB_PCIM_PACKER_SEQ_EN
        chk({tag, "_seq"}, 512'(line_seq_o), 512'(exp_seq));
`endif
        exp_seq = exp_seq + 24'd1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [79:0] d);
        fsb_v_i    = 1'b1;
        fsb_data_i = d;
        #1;
        chk("send_yumi", 512'(fsb_yumi_o), 512'(1));
        cyc();
        fsb_v_i = 1'b0;
    endtask

    task automatic idle(input int n);
        fsb_v_i = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic flush1();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
    endtask

    task automatic check_from_q();
        int c;
        logic [5:0][79:0] s;
        c = int'(line_count_o);
        ncmp++;
        assert (c >= 1 && c <= 6 && c <= q.size()) else begin
            nerr++;
            $error("FAIL rand_count: observed %0d expected 1..%0d", c, q.size());
        end
        if (c >= 1 && c <= 6 && c <= q.size()) begin
            s = '0;
            for (int k = 0; k < c; k++) s[k] = q.pop_front();
            chk_line("rand_line", s, c);
        end
    endtask

    initial begin
        int idx, acc_total, pid, guard;

        reset_i = 1'b1; fsb_v_i = 1'b1; fsb_data_i = 80'hFF;
        flush_i = 1'b0; line_ready_i = 1'b1;
        repeat (2) cyc();
        chk("rst_yumi", 512'(fsb_yumi_o), 512'(0));
        chk("rst_v", 512'(line_v_o), 512'(0));
        chk("rst_data", line_data_o, 512'(0));
        chk("rst_cnt", 512'(line_count_o), 512'(0));
        chk("rst_busy", 512'(busy_o), 512'(0));
        reset_i = 1'b0; fsb_v_i = 1'b0;

        // full line of six packets
        for (int i = 1; i <= 6; i++) send(pk(8'h00, i));
        chk("full_early_v", 512'(line_v_o), 512'(0));
        idle(1);
        chk_line("full", slots(8'h00, 1, 6), 6);
        idle(1);
        chk("full_drain_v", 512'(line_v_o), 512'(0));
        chk("full_drain_busy", 512'(busy_o), 512'(0));

        // idle timeout on a partial line
        send(pk(8'hA0, 1)); send(pk(8'hA0, 2));
        idle(64);
        chk("to_early_v", 512'(line_v_o), 512'(0));
        idle(1);
        chk_line("to", slots(8'hA0, 1, 2), 2);
        idle(1);
        chk("to_drain_v", 512'(line_v_o), 512'(0));

        // timeout in the same cycle as an accept
        send(pk(8'hB0, 1)); send(pk(8'hB0, 2));
        idle(64);
        chk("tox_early_v", 512'(line_v_o), 512'(0));
        send(pk(8'hB0, 3));
        chk_line("tox_old", slots(8'hB0, 1, 2), 2);
        flush1();
        chk_line("tox_new", slots(8'hB0, 3, 1), 1);
        idle(1);
        chk("tox_busy", 512'(busy_o), 512'(0));

        // explicit flush: empty then three packets
        flush1();
        chk("fl0_v", 512'(line_v_o), 512'(0));
        chk("fl0_busy", 512'(busy_o), 512'(0));
        for (int i = 1; i <= 3; i++) send(pk(8'hC0, i));
        flush1();
        chk_line("fl3", slots(8'hC0, 1, 3), 3);
        idle(1);

        // backpressure: 14 offered, 12 fit
        line_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            fsb_v_i = (idx < 14); fsb_data_i = pk(8'hD0, idx + 1);
            #1;
            if (fsb_yumi_o) idx++;
            cyc();
        end
        chk("bp_accepted", 512'(idx), 512'(12));
        fsb_v_i = 1'b1; fsb_data_i = pk(8'hD0, 13);
        #1;
        chk("bp_yumi_blocked", 512'(fsb_yumi_o), 512'(0));
        chk("bp_busy", 512'(busy_o), 512'(1));
        line_ready_i = 1'b1;
        #1;
        chk("bp_yumi_full", 512'(fsb_yumi_o), 512'(0));
        chk_line("bp_l1", slots(8'hD0, 1, 6), 6);
        cyc();
        chk_line("bp_l2", slots(8'hD0, 7, 6), 6);
        send(pk(8'hD0, 13));
        chk("bp_l2_drained", 512'(line_v_o), 512'(0));
        send(pk(8'hD0, 14));
        flush1();
        chk_line("bp_l3", slots(8'hD0, 13, 2), 2);
        idle(1);

        // random scoreboard
        acc_total = 0; pid = 0; guard = 0;
        while (acc_total < 1000 && guard < 6000) begin
            fsb_v_i      = ($urandom_range(0, 9) < 7);
            fsb_data_i   = {16'hC0DE, 32'($urandom), 32'(pid)};
            line_ready_i = 1'($urandom_range(0, 1));
            flush_i      = ($urandom_range(0, 19) == 0);
            #1;
            if (line_v_o && line_ready_i) check_from_q();
            if (fsb_yumi_o) begin
                q.push_back(fsb_data_i);
                pid++;
                acc_total++;
            end
            cyc();
            guard++;
        end
        chk("rand_accepted", 512'(acc_total), 512'(1000));
        fsb_v_i = 1'b0; line_ready_i = 1'b1; flush_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (line_v_o && line_ready_i) check_from_q();
            cyc();
        end
        flush_i = 1'b0;
        chk("rand_left", 512'(q.size()), 512'(0));
        chk("rand_busy", 512'(busy_o), 512'(0));

        // reset mid-operation
        line_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) send(pk(8'hE0, i));
        idle(1);
        for (int i = 7; i <= 10; i++) send(pk(8'hE0, i));
        chk("rm_v_before", 512'(line_v_o), 512'(1));
        reset_i = 1'b1; fsb_v_i = 1'b1; fsb_data_i = pk(8'hE0, 99);
        #1;
        chk("rm_yumi", 512'(fsb_yumi_o), 512'(0));
        cyc();
        chk("rm_v", 512'(line_v_o), 512'(0));
        chk("rm_busy", 512'(busy_o), 512'(0));
        chk("rm_data", line_data_o, 512'(0));
        reset_i = 1'b0; fsb_v_i = 1'b0; line_ready_i = 1'b1;
        exp_seq = '0;
        cyc();
        chk("rm_busy_after", 512'(busy_o), 512'(0));
        send(pk(8'hF0, 1));
        flush1();
        chk_line("post_rst", slots(8'hF0, 1, 1), 1);
        idle(1);

`ifdef FSB_PCIM_PACKER_SEQ_EN
        force dut.seq_q = 24'hFFFFFF;
        #1;
        release dut.seq_q;
        exp_seq = 24'hFFFFFF;
        send(pk(8'hF0, 2));
        flush1();
        chk_line("seq_max", slots(8'hF0, 2, 1), 1);
        send(pk(8'hF0, 3));
        flush1();
        chk_line("seq_wrap", slots(8'hF0, 3, 1), 1);
        idle(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
